logical_operand_stage: RTL and testbench

Registered two-entry operand buffer that sits directly upstream of the team's N-bit logical reduction units (logical AND/OR/XOR of reduced operands). It accepts operand pairs over a valid/ready handshake and presents them stable to the downstream combinational unit until that consumer accepts them. It decouples the producer's timing from the combinational evaluation path. It absorbs one cycle of downstream back-pressure without dropping data.

---
 rtl/logical_pkg.sv | 11 +
 rtl/logical_operand_stage.sv | 110 +++++++++++
 tb/tb_logical_operand_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/logical_pkg.sv
// Shared types for the logical operand stage: occupancy state encoding.
// The per-entry record depends on the operand width, so it is declared in the stage itself.
package logical_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/logical_operand_stage.sv
// Two-entry registered operand buffer in front of the logical reduction units.
// Define LOGICAL_NZ_FLAG_EN to store and present per-operand nonzero flags.
module logical_operand_stage
  import logical_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
`ifdef LOGICAL_NZ_FLAG_EN
  output logic         out_a_nz,
  output logic         out_b_nz,
`endif
  output logic [1:0]   level
);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
`ifdef LOGICAL_NZ_FLAG_EN
    logic         a_nz;
    logic         b_nz;
`endif
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_entry;
  logic   in_ready_q;
  logic   push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  always_comb begin
    in_entry   = '0;
    in_entry.a = in_a;
    in_entry.b = in_b;
`ifdef LOGICAL_NZ_FLAG_EN
    in_entry.a_nz = |in_a;
    in_entry.b_nz = |in_b;
`endif
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = in_entry;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          tail_d  = in_entry;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          head_d = in_entry;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can occur; tail (and its flags) shifts to head.
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign level     = state_q;
  assign out_a     = head_q.a;
  assign out_b     = head_q.b;
`ifdef LOGICAL_NZ_FLAG_EN
  assign out_a_nz  = head_q.a_nz;
  assign out_b_nz  = head_q.b_nz;
`endif

endmodule

// File: tb/tb_logical_operand_stage.sv
// Directed bench for logical_operand_stage: table-driven handshake vectors plus
// hand-written reset, streaming and (with LOGICAL_NZ_FLAG_EN) flag sequences.
module tb_logical_operand_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a, out_b;
  logic [1:0] level;
`ifdef LOGICAL_NZ_FLAG_EN
  logic       out_a_nz, out_b_nz;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  logical_operand_stage #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
`ifdef LOGICAL_NZ_FLAG_EN
    .out_a_nz  (out_a_nz),
    .out_b_nz  (out_b_nz),
`endif
    .level     (level)
  );

  typedef struct {
    logic       iv;
    logic [7:0] a;
    logic [7:0] b;
    logic       ordy;
    logic       ev;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       eir;
    logic [1:0] el;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Back-pressure fill, ignored push while full, drain, then push/pop in ONE.
    vecs[0] = '{1'b1, 8'h01, 8'hF1, 1'b0, 1'b1, 8'h01, 8'hF1, 1'b1, 2'd1};
    vecs[1] = '{1'b1, 8'h02, 8'hF2, 1'b0, 1'b1, 8'h01, 8'hF1, 1'b0, 2'd2};
    vecs[2] = '{1'b1, 8'h03, 8'hF3, 1'b0, 1'b1, 8'h01, 8'hF1, 1'b0, 2'd2};
    vecs[3] = '{1'b1, 8'h03, 8'hF3, 1'b1, 1'b1, 8'h02, 8'hF2, 1'b1, 2'd1};
    vecs[4] = '{1'b1, 8'h03, 8'hF3, 1'b1, 1'b1, 8'h03, 8'hF3, 1'b1, 2'd1};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 2'd0};

    // Reset held with in_valid high, then a single pair.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h00;
    in_b      = 8'h5A;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_level", level, 2'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_a", out_a, 8'h00);
    check("rst_out_b", out_b, 8'h00);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("single_out_valid", out_valid, 1'b1);
    check("single_out_a", out_a, 8'h00);
    check("single_out_b", out_b, 8'h5A);
    check("single_level", level, 2'd1);
    tick();
    check("single_drain_level", level, 2'd0);
    check("single_drain_valid", out_valid, 1'b0);

    // Table-driven handshake vectors.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid  = vecs[i].iv;
      in_a      = vecs[i].a;
      in_b      = vecs[i].b;
      out_ready = vecs[i].ordy;
      tick();
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ev);
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].eir);
      check($sformatf("vec%0d_level", i), level, vecs[i].el);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_out_a", i), out_a, vecs[i].ea);
        check($sformatf("vec%0d_out_b", i), out_b, vecs[i].eb);
      end
    end

    // Streaming: one pair per cycle with out_ready held high.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_a     = 8'(8'h10 + i);
      in_b     = 8'(8'hA0 + i);
      tick();
      check($sformatf("stream%0d_out_a", i), out_a, 8'(8'h10 + i));
      check($sformatf("stream%0d_out_b", i), out_b, 8'(8'hA0 + i));
      check($sformatf("stream%0d_level", i), level, 2'd1);
      check($sformatf("stream%0d_in_ready", i), in_ready, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_level", level, 2'd0);

    // Reset asserted mid-cycle while full.
    do_reset();
    in_valid = 1'b1;
    in_a = 8'h11; in_b = 8'h22;
    tick();
    in_a = 8'h33; in_b = 8'h44;
    tick();
    in_valid = 1'b0;
    check("midrst_pre_level", level, 2'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_level", level, 2'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_a", out_a, 8'h00);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_a = 8'hC3; in_b = 8'h3C;
    tick();
    in_valid = 1'b0;
    check("midrst_new_out_a", out_a, 8'hC3);
    check("midrst_new_out_b", out_b, 8'h3C);
    check("midrst_new_level", level, 2'd1);
    out_ready = 1'b1;
    tick();
    check("midrst_no_stale", out_valid, 1'b0);

`ifdef LOGICAL_NZ_FLAG_EN
    // Flags travel with their entry across the tail-to-head shift.
    do_reset();
    in_valid = 1'b1;
    in_a = 8'h00; in_b = 8'h80;
    tick();
    check("nz0_a", out_a_nz, 1'b0);
    check("nz0_b", out_b_nz, 1'b1);
    in_a = 8'h01; in_b = 8'h00;
    tick();
    in_valid = 1'b0;
    check("nz_full_a", out_a_nz, 1'b0);
    check("nz_full_b", out_b_nz, 1'b1);
    out_ready = 1'b1;
    tick();
    check("nz1_a", out_a_nz, 1'b1);
    check("nz1_b", out_b_nz, 1'b0);
    check("nz1_out_a", out_a, 8'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
